// File: rtl/column_seq_pkg.sv
// Shared types and default sizing for the column sequencer.
package column_seq_pkg;

  localparam int DEF_COL_W    = 32;
  localparam int DEF_NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/column_sequencer_slot_insert.sv
// Column slot extract/insert. Column 0 occupies the MSBs of the state word.
module slot_insert #(
  parameter int COL_W    = 32,
  parameter int NUM_COLS = 4,
  localparam int STATE_W = COL_W * NUM_COLS,
  localparam int IDX_W   = $clog2(NUM_COLS)
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [COL_W-1:0]   col_i,
  output logic [COL_W-1:0]   col_o,
  output logic [STATE_W-1:0] state_o
);

  // Select the indexed column and build the state with that slot replaced.
  always_comb begin
    col_o   = '0;
    state_o = state_i;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (idx_i == IDX_W'(i)) begin
        col_o = state_i[STATE_W-1-i*COL_W -: COL_W];
        state_o[STATE_W-1-i*COL_W -: COL_W] = col_i;
      end
    end
  end

endmodule

// File: rtl/column_sequencer.sv
// Column sequencer: walks enabled state columns through an external engine
// and writes each transformed column back in place.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; captures state, mask and direction
//   ST_ISSUE | col_valid high, holding col_out/col_idx until col_ready
//   ST_WAIT  | column handed off, waiting for res_valid to write it back
//   ST_DONE  | one-cycle done pulse, then back to idle
module column_sequencer
  import column_seq_pkg::*;
#(
  parameter int COL_W    = DEF_COL_W,
  parameter int NUM_COLS = DEF_NUM_COLS,
  localparam int STATE_W = COL_W * NUM_COLS,
  localparam int IDX_W   = $clog2(NUM_COLS)
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                start,
  input  logic [STATE_W-1:0]  state_in,
  input  logic [NUM_COLS-1:0] col_mask,
  input  logic                reverse,
  input  logic                abort,
  output logic [COL_W-1:0]    col_out,
  output logic [IDX_W-1:0]    col_idx,
  output logic                col_valid,
  input  logic                col_ready,
  input  logic [COL_W-1:0]    res_in,
  input  logic                res_valid,
  output logic [STATE_W-1:0]  state_out,
  output logic                busy,
  output logic                done
);

  seq_state_e          fsm_q, fsm_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [NUM_COLS-1:0] mask_q, mask_d;
  logic                rev_q, rev_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [STATE_W-1:0]  ins_state;
  logic [IDX_W:0]      nx_start, nx_cont;

  // Priority search for the next enabled column in visit order. The MSB of
  // the result flags that one was found. from_start ignores cur and returns
  // the first enabled column of the whole pass.
  function automatic logic [IDX_W:0] next_col(input logic [NUM_COLS-1:0] m,
                                              input logic                rev,
                                              input logic [IDX_W-1:0]    cur,
                                              input logic                from_start);
    logic [IDX_W:0] r;
    r = '0;
    if (!rev) begin
      for (int i = NUM_COLS - 1; i >= 0; i--) begin
        if (m[i] && (from_start || i > int'(cur))) r = {1'b1, IDX_W'(i)};
      end
    end else begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (m[i] && (from_start || i < int'(cur))) r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  assign nx_start = next_col(col_mask, reverse, {IDX_W{1'b0}}, 1'b1);
  assign nx_cont  = next_col(mask_q, rev_q, idx_q, 1'b0);

  slot_insert #(
    .COL_W    (COL_W),
    .NUM_COLS (NUM_COLS)
  ) u_slot (
    .state_i (state_q),
    .idx_i   (idx_q),
    .col_i   (res_in),
    .col_o   (col_out),
    .state_o (ins_state)
  );

  assign col_idx   = idx_q;
  assign col_valid = (fsm_q == ST_ISSUE);
  assign busy      = (fsm_q == ST_ISSUE) || (fsm_q == ST_WAIT);
  assign done      = (fsm_q == ST_DONE);
  assign state_out = state_q;

  // Next-state and datapath update; abort wins over a coincident result.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    mask_d  = mask_q;
    rev_d   = rev_q;
    idx_d   = idx_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = state_in;
          mask_d  = col_mask;
          rev_d   = reverse;
          if (nx_start[IDX_W]) begin
            idx_d = nx_start[IDX_W-1:0];
            fsm_d = ST_ISSUE;
          end else begin
            fsm_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort)          fsm_d = ST_IDLE;
        else if (col_ready) fsm_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort) begin
          fsm_d = ST_IDLE;
        end else if (res_valid) begin
          state_d = ins_state;
          if (nx_cont[IDX_W]) begin
            idx_d = nx_cont[IDX_W-1:0];
            fsm_d = ST_ISSUE;
          end else begin
            fsm_d = ST_DONE;
          end
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      mask_q  <= '0;
      rev_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      mask_q  <= mask_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_column_sequencer.sv
// Directed bench for column_sequencer with a small reactive engine model.
module tb_column_sequencer;

  localparam logic [127:0] ST_A    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] EXP_ALL = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] EXP_SPR = 128'hFFEEDDCC_44556677_77665544_CCDDEEFF;
  localparam logic [127:0] EXP_ABT = 128'hFFEEDDCC_BBAA9988_8899AABB_CCDDEEFF;

  logic         CLK, RESET_N;
  logic         start, reverse, abort;
  logic [127:0] state_in, state_out;
  logic [3:0]   col_mask;
  logic [31:0]  col_out, res_in;
  logic [1:0]   col_idx;
  logic         col_valid, col_ready, res_valid, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // engine model / monitor state
  int          cyc = 0, done_cnt = 0, done_cyc = 0, last_res_cyc = 0;
  int          ready_dly = 0, stall = 0, stall_cycles = 0, stable_err = 0, log_n = 0;
  bit          spur_en = 0, pend = 0;
  logic [31:0] pend_col, hold_col, log_w;
  logic [1:0]  hold_idx;

  column_sequencer dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .start     (start),
    .state_in  (state_in),
    .col_mask  (col_mask),
    .reverse   (reverse),
    .abort     (abort),
    .col_out   (col_out),
    .col_idx   (col_idx),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .res_in    (res_in),
    .res_valid (res_valid),
    .state_out (state_out),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Engine: returns ~col one cycle after acceptance, optional ready delay
  // and spurious res_valid while a column is being offered.
  initial begin
    col_ready = 1'b0;
    res_valid = 1'b0;
    res_in    = '0;
    log_w     = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      col_ready = 1'b0;
      res_valid = 1'b0;
      res_in    = '0;
      if (!RESET_N) begin
        pend  = 0;
        stall = 0;
      end else if (pend) begin
        res_valid    = 1'b1;
        res_in       = ~pend_col;
        pend         = 0;
        last_res_cyc = cyc;
      end else if (col_valid) begin
        if (stall == 0) begin
          hold_col = col_out;
          hold_idx = col_idx;
        end else if (col_out !== hold_col || col_idx !== hold_idx) begin
          stable_err++;
        end
        if (spur_en) begin
          res_valid = 1'b1;
          res_in    = 32'hDEAD_BEEF;
        end
        if (stall >= ready_dly) begin
          col_ready = 1'b1;
          pend      = 1;
          pend_col  = col_out;
          log_w     = {log_w[27:0], 2'b00, col_idx};
          log_n++;
          stall     = 0;
        end else begin
          stall++;
          stall_cycles++;
        end
      end
    end
  end

  // Applies a start pulse; returns at the negedge of cycle t+1.
  task automatic launch(input logic [127:0] st, input logic [3:0] m, input logic rev);
    @(negedge CLK);
    state_in     = st;
    col_mask     = m;
    reverse      = rev;
    start        = 1'b1;
    done_cnt     = 0;
    log_w        = '0;
    log_n        = 0;
    stable_err   = 0;
    stall_cycles = 0;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 300 && done_cnt == 0; k++) @(negedge CLK);
    if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
    repeat (3) @(negedge CLK);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    RESET_N  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    reverse  = 1'b0;
    col_mask = '0;
    state_in = '0;
    #3;
    chk("rst_state", state_out, 0);
    chk("rst_valid", col_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_col_out", col_out, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;

    // forward full pass
    ready_dly = 0;
    spur_en   = 0;
    launch(ST_A, 4'b1111, 1'b0);
    chk("fwd_valid_t1", col_valid, 1);
    chk("fwd_idx_t1", col_idx, 0);
    chk("fwd_col_t1", col_out, 32'h00112233);
    wait_done("fwd");
    chk("fwd_state", state_out, EXP_ALL);
    chk("fwd_order", log_w, 32'h0000_0123);
    chk("fwd_done_lat", done_cyc - last_res_cyc, 1);

    // sparse mask
    launch(ST_A, 4'b0101, 1'b0);
    wait_done("spr");
    chk("spr_state", state_out, EXP_SPR);
    chk("spr_count", log_n, 2);
    chk("spr_order", log_w, 32'h0000_0002);

    // empty mask
    launch(ST_A, 4'b0000, 1'b0);
    chk("emp_done_t1", done, 1);
    chk("emp_valid", col_valid, 0);
    chk("emp_busy", busy, 0);
    repeat (2) @(negedge CLK);
    chk("emp_done_once", done_cnt, 1);
    chk("emp_state", state_out, ST_A);
    chk("emp_none", log_n, 0);

    // reverse with backpressure and spurious res_valid in ISSUE
    ready_dly = 3;
    spur_en   = 1;
    launch(ST_A, 4'b1111, 1'b1);
    wait_done("rev");
    chk("rev_state", state_out, EXP_ALL);
    chk("rev_order", log_w, 32'h0000_3210);
    chk("rev_stable", stable_err, 0);
    chk("rev_stalls", stall_cycles, 12);
    ready_dly = 0;
    spur_en   = 0;

    // reset mid-WAIT
    launch(ST_A, 4'b1111, 1'b0);
    for (k = 0; k < 50 && !(busy && !col_valid); k++) @(negedge CLK);
    chk("rstw_in_wait", busy && !col_valid, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rstw_state", state_out, 0);
    chk("rstw_valid", col_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_done", done, 0);
    chk("rstw_idx", col_idx, 0);
    chk("rstw_col_out", col_out, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    launch(ST_A, 4'b1111, 1'b0);
    wait_done("post_rst");
    chk("post_rst_state", state_out, EXP_ALL);

    // abort after column 1 written, with start pulsed while busy
    launch(ST_A, 4'b1111, 1'b0);
    for (k = 0; k < 50 && !(col_valid && col_idx == 2'd2); k++) @(negedge CLK);
    chk("abt_reach_col2", col_valid && col_idx == 2'd2, 1);
    abort    = 1'b1;
    start    = 1'b1;
    state_in = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    @(negedge CLK);
    abort = 1'b0;
    start = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_valid", col_valid, 0);
    chk("abt_state", state_out, EXP_ABT);
    repeat (4) @(negedge CLK);
    chk("abt_no_done", done_cnt, 0);
    chk("abt_no_restart", busy, 0);
    chk("abt_state_hold", state_out, EXP_ABT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
